// File: rtl/reg_alu_seq_if.sv
// Command/program bus between the reg_alu control-word sequencer and its host.
// Optional carry_flag exists only when REG_ALU_SEQ_CARRY_EN is defined.
interface reg_alu_seq_if #(
  parameter int AW = 4
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [28:0]   prog_data;
  logic          start;
  logic [AW:0]   len;
  logic          cout;
  logic          sel;
  logic          wr;
  logic [1:0]    op;
  logic [2:0]    rd_addr_a;
  logic [2:0]    rd_addr_b;
  logic [2:0]    wr_addr;
  logic [15:0]   d_in;
  logic          busy;
  logic          done;
  logic [AW:0]   pc;
`ifdef REG_ALU_SEQ_CARRY_EN
  logic          carry_flag;
`endif

  modport master (
    output prog_we, prog_addr, prog_data,
    output start, len, cout,
    input  sel, wr, op,
    input  rd_addr_a, rd_addr_b, wr_addr,
    input  d_in, busy, done, pc
`ifdef REG_ALU_SEQ_CARRY_EN
    , input carry_flag
`endif
  );

  modport slave (
    input  prog_we, prog_addr, prog_data,
    input  start, len, cout,
    output sel, wr, op,
    output rd_addr_a, rd_addr_b, wr_addr,
    output d_in, busy, done, pc
`ifdef REG_ALU_SEQ_CARRY_EN
    , output carry_flag
`endif
  );
endinterface

// File: rtl/reg_alu_seq.sv
// Control-word sequencer feeding reg_alu: replays a stored program on start.
// Define REG_ALU_SEQ_CARRY_EN to add the sticky carry_flag output.
module reg_alu_seq #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  reg_alu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] pc_q, pc_d;
  logic [AW:0] len_q, len_d;
  logic [28:0] word_q, word_d;
  logic        done_q, done_d;
  logic        we_ok;
  logic        start_ok;

  logic [28:0] mem [DEPTH];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    word_d   = word_q;
    done_d   = 1'b0;
    we_ok    = 1'b0;
    start_ok = 1'b0;
    unique case (state_q)
      IDLE: begin
        word_d = '0;
        we_ok  = bus.prog_we;
        if (bus.start) begin
          start_ok = 1'b1;
          pc_d     = '0;
          if (bus.len > (AW+1)'(DEPTH))
            len_d = (AW+1)'(DEPTH);
          else
            len_d = bus.len;
          if (bus.len == '0)
            state_d = DONE;
          else
            state_d = RUN;
        end
      end
      RUN: begin
        word_d = mem[pc_q[AW-1:0]];
        pc_d   = pc_q + (AW+1)'(1);
        if (pc_q == len_q - (AW+1)'(1))
          state_d = DONE;
      end
      DONE: begin
        // first DONE edge raises done, second returns to IDLE
        word_d = '0;
        if (done_q)
          state_d = IDLE;
        else
          done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        word_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && we_ok)
      mem[bus.prog_addr] <= bus.prog_data;
  end

  assign bus.sel       = word_q[28];
  assign bus.wr        = word_q[27];
  assign bus.op        = word_q[26:25];
  assign bus.rd_addr_a = word_q[24:22];
  assign bus.rd_addr_b = word_q[21:19];
  assign bus.wr_addr   = word_q[18:16];
  assign bus.d_in      = word_q[15:0];
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.pc        = pc_q;

`ifdef REG_ALU_SEQ_CARRY_EN
  logic carry_q, carry_d;
  logic alu_wb;

  // word_q is the word reg_alu is consuming at this edge
  assign alu_wb = (state_q != IDLE) && word_q[28] && word_q[27];

  always_comb begin
    carry_d = carry_q;
    if (start_ok)
      carry_d = 1'b0;
    else if (alu_wb)
      carry_d = carry_q | bus.cout;
  end

  always_ff @(posedge clk) begin
    if (reset)
      carry_q <= 1'b0;
    else
      carry_q <= carry_d;
  end

  assign bus.carry_flag = carry_q;
`else
  logic unused_cout;
  assign unused_cout = bus.cout ^ start_ok;
`endif

endmodule

// File: tb/tb_reg_alu_seq.sv
// Scoreboard bench for reg_alu_seq: stimulus pushes expected words,
// a negedge monitor pops them whenever a command or done appears.
module tb_reg_alu_seq;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_alu_seq_if #(.AW(AW)) bus ();

  reg_alu_seq #(.DEPTH(16), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [28:0] w;
    logic        d;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [28:0] prog [16];

  function automatic logic [28:0] mk(logic s, logic w, logic [1:0] o,
                                     logic [2:0] a, logic [2:0] b,
                                     logic [2:0] wa, logic [15:0] d);
    return {s, w, o, a, b, wa, d};
  endfunction

  function automatic logic [28:0] cmd_now();
    return {bus.sel, bus.wr, bus.op, bus.rd_addr_a,
            bus.rd_addr_b, bus.wr_addr, bus.d_in};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && (cmd_now() != '0 || bus.done)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected: got %h done=%b expected none",
                 cmd_now(), bus.done);
      end else begin
        e = q.pop_front();
        if (cmd_now() !== e.w || bus.done !== e.d) begin
          errors++;
          $display("FAIL mon_word: got %h done=%b expected %h done=%b",
                   cmd_now(), bus.done, e.w, e.d);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input bit with_done);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.w = prog[i];
      x.d = 1'b0;
      q.push_back(x);
    end
    if (with_done) begin
      x.w = '0;
      x.d = 1'b1;
      q.push_back(x);
    end
  endtask

  task automatic start_run(input int n);
    int eff;
    eff = (n > 16) ? 16 : n;
    push_words(eff, 1'b1);
    bus.start = 1'b1;
    bus.len   = 5'(n);
    tick();
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
  endtask

  task automatic run_and_check(input int n);
    int eff;
    eff = (n > 16) ? 16 : n;
    start_run(n);
    chk("c0_busy", 32'(bus.busy), 32'd1);
    chk("c0_pc", 32'(bus.pc), 32'd0);
    chk("c0_cmd", 32'(cmd_now()), 32'd0);
    for (int c = 1; c <= eff + 2; c++) begin
      tick();
      chk("run_busy", 32'(bus.busy), 32'(c <= eff + 1));
      chk("run_done", 32'(bus.done), 32'(c == eff + 1));
      if (c <= eff)
        chk("run_pc", 32'(bus.pc), 32'(c));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.cout      = 1'b0;
    repeat (3) tick();
    chk("rst_cmd", 32'(cmd_now()), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_pc", 32'(bus.pc), 32'd0);
    reset = 1'b0;

    prog[0] = mk(1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 3'd1, 16'h1234);
    prog[1] = mk(1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 3'd2, 16'h00ff);
    prog[2] = mk(1'b1, 1'b1, 2'b00, 3'd1, 3'd2, 3'd3, 16'h0001);
    prog[3] = mk(1'b1, 1'b0, 2'b01, 3'd3, 3'd1, 3'd0, 16'h0002);
    prog[4] = mk(1'b1, 1'b1, 2'b10, 3'd3, 3'd2, 3'd4, 16'h0003);
    prog[5] = mk(1'b0, 1'b1, 2'b00, 3'd0, 3'd0, 3'd5, 16'hbeef);
    prog[6] = mk(1'b1, 1'b0, 2'b11, 3'd5, 3'd4, 3'd0, 16'h0004);
    prog[7] = mk(1'b1, 1'b1, 2'b11, 3'd5, 3'd1, 3'd6, 16'h0005);
    for (int i = 8; i < 16; i++)
      prog[i] = mk(1'b1, 1'b0, 2'b01, 3'(i), ~3'(i), 3'd0,
                   16'(16'ha000 + i));

    for (int i = 0; i < 16; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'(i);
      bus.prog_data = prog[i];
      tick();
      if (i % 5 == 0) begin
        chk("load_cmd", 32'(cmd_now()), 32'd0);
        chk("load_busy", 32'(bus.busy), 32'd0);
      end
    end
    bus.prog_we = 1'b0;
    tick();

    run_and_check(8);
    tick();
    run_and_check(0);
    tick();

    start_run(8);
    for (int c = 1; c <= 10; c++) begin
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      if (c == 4) begin
        bus.start = 1'b1;
        bus.len   = 5'd2;
      end
      if (c == 5) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd0;
        bus.prog_data = 29'h1fff_ffff;
      end
      tick();
      chk("intr_done", 32'(bus.done), 32'(c == 9));
      chk("intr_busy", 32'(bus.busy), 32'(c <= 9));
    end
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    tick();

    push_words(4, 1'b0);
    bus.start = 1'b1;
    bus.len   = 5'd8;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    chk("abort_cmd", 32'(cmd_now()), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_pc", 32'(bus.pc), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("abort_nodone", 32'(bus.done), 32'd0);
    end
    chk("abort_q", 32'(q.size()), 32'd0);
    run_and_check(8);
    tick();

    prog[0]       = mk(1'b1, 1'b1, 2'b01, 3'd7, 3'd6, 3'd7, 16'h5a5a);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd0;
    bus.prog_data = prog[0];
    run_and_check(1);
    tick();

    run_and_check(20);
    tick();

`ifdef REG_ALU_SEQ_CARRY_EN
    prog[0]       = mk(1'b1, 1'b1, 2'b00, 3'd1, 3'd2, 3'd3, 16'h0001);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd0;
    bus.prog_data = prog[0];
    tick();
    bus.prog_we = 1'b0;
    start_run(2);
    chk("cy_c0", 32'(bus.carry_flag), 32'd0);
    tick();
    bus.cout = 1'b1;
    tick();
    bus.cout = 1'b0;
    chk("cy_set", 32'(bus.carry_flag), 32'd1);
    tick();
    chk("cy_hold_done", 32'(bus.carry_flag), 32'd1);
    tick();
    tick();
    chk("cy_hold_idle", 32'(bus.carry_flag), 32'd1);
    start_run(1);
    chk("cy_clear", 32'(bus.carry_flag), 32'd0);
    repeat (3) tick();
`endif

    repeat (3) tick();
    chk("final_q", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
